// File: rtl/mem_arb_pkg.sv
// Shared defaults for the memory-port arbiter: requester count, data and
// address widths, and the derived pointer width.
package mem_arb_pkg;
  localparam int N_REQ_DEF   = 4;
  localparam int D_WIDTH_DEF = 64;
  localparam int A_WIDTH_DEF = 7;
  localparam int PTR_W_DEF   = $clog2(N_REQ_DEF);
endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans upward from the pointer with wrap-around and
// moves the pointer one past the winner on every grant.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     i_req,
  output logic [N-1:0]     o_gnt,
  output logic             o_gnt_vld,
  output logic [PTR_W-1:0] o_gnt_idx
);
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_cand;
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W-1:0] w_nxt;
  logic             w_found;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = PTR_W'((int'(r_ptr) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  always_comb begin
    o_gnt        = '0;
    o_gnt[w_idx] = w_found;
  end

  assign o_gnt_vld = w_found;
  assign o_gnt_idx = w_idx;
  assign w_nxt     = (w_idx == PTR_W'(N - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clock) begin
    if (reset)        r_ptr <= '0;
    else if (w_found) r_ptr <= w_nxt;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one dual-port memory between N_REQ requesters: one write and one
// read granted per cycle by independent round-robin arbiters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int N_REQ   = N_REQ_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*A_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*D_WIDTH-1:0]   req_wdata,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [D_WIDTH-1:0]         rsp_data,
  output logic                       mem_we,
  output logic [A_WIDTH-1:0]         mem_write_addr,
  output logic [D_WIDTH-1:0]         mem_data,
  output logic [A_WIDTH-1:0]         mem_read_addr,
  input  logic [D_WIDTH-1:0]         mem_q
);
  localparam int PTR_W = $clog2(N_REQ);

  logic [N_REQ-1:0][A_WIDTH-1:0] w_addr;
  logic [N_REQ-1:0][D_WIDTH-1:0] w_wdata;
  logic [N_REQ-1:0]              w_wreq, w_rreq, w_wgnt, w_rgnt;
  logic                          w_wvld, w_rvld;
  logic [PTR_W-1:0]              w_widx, w_ridx;
  logic [N_REQ-1:0]              r_rsp_valid;
  logic [D_WIDTH-1:0]            r_rsp_data;

  assign w_addr  = req_addr;
  assign w_wdata = req_wdata;

  // Requests are masked during reset so no grant (and no write) can occur.
  assign w_wreq = {N_REQ{~reset}} & req_valid &  req_we;
  assign w_rreq = {N_REQ{~reset}} & req_valid & ~req_we;

  rr_arbiter #(.N(N_REQ)) u_warb (
    .clock     (clock),
    .reset     (reset),
    .i_req     (w_wreq),
    .o_gnt     (w_wgnt),
    .o_gnt_vld (w_wvld),
    .o_gnt_idx (w_widx)
  );

  rr_arbiter #(.N(N_REQ)) u_rarb (
    .clock     (clock),
    .reset     (reset),
    .i_req     (w_rreq),
    .o_gnt     (w_rgnt),
    .o_gnt_vld (w_rvld),
    .o_gnt_idx (w_ridx)
  );

  assign req_ready      = w_wgnt | w_rgnt;
  assign mem_we         = w_wvld;
  assign mem_write_addr = w_addr[w_widx];
  assign mem_data       = w_wdata[w_widx];
  assign mem_read_addr  = w_addr[w_ridx];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_rgnt;
      if (w_rvld) r_rsp_data <= mem_q;
    end
  end

  // A response due in a reset cycle is dropped, not delivered late.
  assign rsp_valid = r_rsp_valid & {N_REQ{~reset}};
  assign rsp_data  = r_rsp_data;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin controller that shares one dual-port `Mem` instance between `N_REQ` requesters. Each requester issues read or write commands over a valid/ready handshake. Every cycle the block grants at most one write to the write port and at most one read to the read port, each chosen by its own round-robin pointer. Read data is registered and returned one cycle after the grant. The block sits between the per-engine memory clients and the `Mem` instance; the `Mem` `read_clock` and `write_clock` are both tied to `clock`.

## Interface
Parameters:
- `D_WIDTH`, 64, data word width (matches `Mem`).
- `A_WIDTH`, 7, address width (matches `Mem`).
- `N_REQ`, 4, number of requesters, ≥2.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  command valid, one bit per requester.
- `req_we`  in  N_REQ  1 = write, 0 = read.
- `req_addr`  in  N_REQ*A_WIDTH  packed addresses; requester i occupies slice [i*A_WIDTH +: A_WIDTH].
- `req_wdata`  in  N_REQ*D_WIDTH  packed write data, same packing.
- `req_ready`  out  N_REQ  grant; a command transfers when valid & ready.
- `rsp_valid`  out  N_REQ  one-hot read-response valid.
- `rsp_data`  out  D_WIDTH  read data, shared by all requesters, qualified by `rsp_valid`.
- `mem_we`  out  1  to `Mem.we`.
- `mem_write_addr`  out  A_WIDTH  to `Mem.write_addr`.
- `mem_data`  out  D_WIDTH  to `Mem.data`.
- `mem_read_addr`  out  A_WIDTH  to `Mem.read_addr`.
- `mem_q`  in  D_WIDTH  from `Mem.q`, combinational read.

## Operation
- **Two independent arbiters.**
  - The write arbiter sees `wreq[i] = req_valid[i] & req_we[i]`.
  - The read arbiter sees `rreq[i] = req_valid[i] & ~req_we[i]`.
  - A requester presents only one command at a time, so at most one arbiter can grant a given requester.
- **Round-robin.**
  - Each arbiter has a pointer `ptr` of width clog2(N_REQ).
  - The winner is the first requesting index found scanning from `ptr` upward with wrap-around.
  - After a grant to index g, `ptr` becomes (g+1) mod N_REQ. With no grant, `ptr` holds.
- **Outputs.** `req_ready[i]` is 1 iff i is the write winner or the read winner.
- **Write grant.**
  - `mem_we` = 1, with `mem_write_addr` and `mem_data` taken from the winner.
  - The data is committed to `Mem` at the end of the grant cycle.
  - With no write grant, `mem_we` = 0; the address and data outputs are don't-care.
- **Read grant.**
  - `mem_read_addr` is driven from the winner.
  - `mem_q` is registered into `rsp_data` at the end of the cycle.
  - `rsp_valid[winner]` is 1 in the next cycle; otherwise `rsp_valid` is 0.
- **Read/write to the same address in the same cycle.** The read returns the old (pre-write) data. This follows from the combinational read and the edge-triggered write.
- **Requester obligations.**
  - Hold `req_valid`, `req_we`, `req_addr` and `req_wdata` stable until `req_ready`.
  - A requester may issue back-to-back reads; responses return in order, one per grant.
- **Reset.**
  - Both pointers reset to 0.
  - `rsp_valid` = 0, `rsp_data` = 0.
  - While `reset` is high, `req_ready` = 0 and `mem_we` = 0 (combinationally gated), so no writes occur.
  - Reset asserted the cycle after a read grant suppresses that response: `rsp_valid` = 0 next cycle.

## Timing
- `req_ready`, `mem_we`, `mem_write_addr`, `mem_data` and `mem_read_addr` are combinational from `req_*` and the pointers. There are no combinational paths from `req_ready` back to the inputs.
- Write latency: committed at the grant edge; visible to a read granted in the following cycle.
- Read latency: 1 cycle from grant to `rsp_valid`.
- Throughput: 1 read + 1 write per cycle, sustained.
- Fairness: a continuously valid requester is granted within N_REQ cycles of its arbiter.

## Structure
- Package `mem_arb_pkg` holds:
  - the default `N_REQ`, `D_WIDTH` and `A_WIDTH` constants;
  - the `PTR_W = $clog2(N_REQ)` localparam pattern.
- Sub-module `rr_arbiter`, parameterized by N, is instantiated twice (write and read). It contains:
  - request vector in;
  - one-hot grant out;
  - grant-valid out;
  - the pointer register with synchronous reset.
- The top level handles request splitting, the mux of the winner's address and data, and the response register.

## Test plan
All scenarios use N_REQ=4 with a `Mem` instance attached.
- **Reset.** Hold `reset` for 2 cycles with all `req_valid` = 1 → `req_ready` = 0, `mem_we` = 0, `rsp_valid` = 0. After release, the first grants go to requester 0.
- **Write then read.**
  - Cycle 0: requester 2 writes 0xDEADBEEF to address 5 → ready[2] = 1, `mem_we` = 1.
  - Cycle 1: requester 1 reads address 5 → `rsp_valid` = 4'b0010 and `rsp_data` = 0xDEADBEEF in cycle 2.
- **Same-cycle collision.**
  - Address 9 holds 0x11; requester 0 writes 0x22 to address 9 while requester 3 reads address 9 → both ready; response is 0x11.
  - A read in the following cycle returns 0x22.
- **Round-robin.** All 4 requesters hold write-valid for 8 cycles → grants in order 0,1,2,3,0,1,2,3, one per cycle.
- **Mixed fairness.** Requesters 0 and 1 read continuously while 2 and 3 write continuously for 4 cycles →
  - reads alternate 0,1;
  - writes alternate 2,3;
  - 2 grants per cycle.
- **Reset mid-read.** Read granted in cycle t, `reset` asserted in cycle t+1 → `rsp_valid` = 0 in t+1; pointers return to 0.
